vga_scene_sequencer: RTL
========================

VGA_SCENE_SEQUENCER -- requirements
Module: vga_scene_sequencer

Interface
REQ-001 Parameter HOLD_FRAMES, default 120: frames spent in HOLD per scene (legal 1..255).
REQ-002 Parameter FADE_DIV, default 8: frames per fade level step (legal 1..255).
REQ-003 Parameter SCROLL_STEP, default 1: scroll_x increment per HOLD frame (legal 0..639).
REQ-004 Parameter NUM_SCENES, default 4: scene count (legal 1..4).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 vsync  input  1  vsync from the sync generator, treated as active-high pulse.
REQ-008 pause  input  1  level; freezes sequencing while high.
REQ-009 skip  input  1  single-cycle request to end the current scene early.
REQ-010 frame_tick  output  1  one-cycle pulse per detected frame start.
REQ-011 scroll_x  output  10  horizontal scroll offset, 0..639.
REQ-012 fade  output  2  brightness level, 0 = black, 3 = full.
REQ-013 scene_id  output  2  current scene index.
REQ-014 state  output  2  debug: FADE_IN=0, HOLD=1, FADE_OUT=2, NEXT=3.

Function
REQ-015 Frame start: vsync high this cycle and low the previous cycle; frame_tick SHALL be asserted exactly one cycle, the cycle after detection.
REQ-016 All sequencing SHALL advance only on the clock edge where frame_tick is high; outputs change the cycle after frame_tick.
REQ-017 Frame counter fcnt (8 bit) SHALL count ticks within a fade level or HOLD and clear on every level or state change.
REQ-018 FADE_IN: when fcnt reaches FADE_DIV-1, fade+1; tick with fade==3 and fcnt==FADE_DIV-1 -> HOLD, fade stays 3.
REQ-019 HOLD: each tick scroll_x += SCROLL_STEP modulo 640 (sum >= 640 -> subtract 640); tick with fcnt==HOLD_FRAMES-1 -> FADE_OUT.
REQ-020 FADE_OUT: mirror of FADE_IN counting down; reaching fade==0 at FADE_DIV boundary -> NEXT.
REQ-021 NEXT: one tick; scene_id+1, wrapping to 0 after NUM_SCENES-1; scroll_x cleared to 0; -> FADE_IN with fade 0.
REQ-022 skip SHALL set skip_pending; at the next tick in FADE_IN or HOLD, state -> FADE_OUT with fade unchanged, fcnt cleared, skip_pending cleared.
REQ-023 skip_pending SHALL be cleared without effect when consumed in FADE_OUT or NEXT.
REQ-024 pause high at a tick: no state, fcnt, fade, scroll_x or scene_id change; frame_tick still pulses; skip_pending retained.
REQ-025 skip and tick in the same cycle: skip SHALL be latched and applied at the following tick.
REQ-026 Second skip while pending: no additional effect.

Reset
REQ-027 On reset: state=FADE_IN, fade=0, scroll_x=0, scene_id=0, fcnt=0, skip_pending=0, frame_tick=0.
REQ-028 Previous-vsync register SHALL reset to 1 so vsync high at reset release yields no tick.
REQ-029 Reset asserted mid-frame or mid-fade SHALL take effect on the next edge, overriding any tick.

Structure
REQ-030 Shared package: H_ACTIVE=640, state encodings, fade width.
REQ-031 One sub-module, vga_frame_tick: vsync edge detector plus registered frame_tick.
REQ-032 All registered outputs; no combinational path from inputs to outputs.

Verification (HOLD_FRAMES=4, FADE_DIV=2, SCROLL_STEP=200, NUM_SCENES=2)
REQ-033 Reset, 8 ticks -> fade 0,1,1,2,2,3,3 then state HOLD after 8th tick.
REQ-034 HOLD 4 ticks -> scroll_x 200,400,600,160; then FADE_OUT.
REQ-035 Full two scenes -> scene_id 0,1,0 with scroll_x 0 at each NEXT.
REQ-036 skip pulse in HOLD at fcnt=1 -> next tick state FADE_OUT, fade 3, scroll_x frozen.
REQ-037 pause high across 3 ticks in FADE_IN plus skip -> 3 frame_tick pulses, no output change; skip applied on first unpaused tick.
REQ-038 vsync high at reset release -> no frame_tick; reset at fade=2 -> all outputs at REQ-027 values next cycle.

Source files
------------

// File: rtl/vga_scene_sequencer_pkg.sv
// vga_scene_sequencer_pkg: shared constants, state encoding and scroll helper
// Revision: 1.0
`default_nettype none

package vga_scene_sequencer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int FADE_W   = 2;
  localparam int SCROLL_W = 10;

  localparam logic [FADE_W-1:0] FADE_MAX = 2'd3;
  localparam logic [FADE_W-1:0] FADE_MIN = 2'd0;

  typedef enum logic [1:0] {
    ST_FADE_IN  = 2'd0,
    ST_HOLD     = 2'd1,
    ST_FADE_OUT = 2'd2,
    ST_NEXT     = 2'd3
  } state_e;

  // Both operands are below H_ACTIVE, so a single conditional subtract wraps correctly.
  function automatic logic [SCROLL_W-1:0] scroll_add(input logic [SCROLL_W-1:0] cur,
                                                     input logic [SCROLL_W-1:0] step);
    logic [SCROLL_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= (SCROLL_W+1)'(H_ACTIVE)) begin
      sum = sum - (SCROLL_W+1)'(H_ACTIVE);
    end
    return sum[SCROLL_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: vsync rising-edge detector with a registered one-cycle frame tick
// Revision: 1.0
`default_nettype none

module vga_frame_tick (
  input  logic clk_i,
  input  logic reset_i,
  input  logic vsync_i,
  output logic frame_tick_o
);

  logic vsync_prev_q;
  logic frame_tick_q;

  // Previous vsync resets high so a vsync already high at reset release is not a frame start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_prev_q <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_i;
      frame_tick_q <= vsync_i & ~vsync_prev_q;
    end
  end

  assign frame_tick_o = frame_tick_q;

endmodule

`default_nettype wire

// File: rtl/vga_scene_sequencer.sv
// vga_scene_sequencer: per-frame fade-in / hold+scroll / fade-out scene sequencer
// Revision: 1.0
`default_nettype none

module vga_scene_sequencer
  import vga_scene_sequencer_pkg::*;
#(
  parameter int HOLD_FRAMES = 120,
  parameter int FADE_DIV    = 8,
  parameter int SCROLL_STEP = 1,
  parameter int NUM_SCENES  = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                vsync_i,
  input  logic                pause_i,
  input  logic                skip_i,
  output logic                frame_tick_o,
  output logic [SCROLL_W-1:0] scroll_x_o,
  output logic [FADE_W-1:0]   fade_o,
  output logic [1:0]          scene_id_o,
  output logic [1:0]          state_o
);

  localparam logic [7:0]          HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]          FADE_LAST  = 8'(FADE_DIV - 1);
  localparam logic [1:0]          SCENE_LAST = 2'(NUM_SCENES - 1);
  localparam logic [SCROLL_W-1:0] STEP       = SCROLL_W'(SCROLL_STEP);

  logic                frame_tick;
  logic                advance;
  state_e              state_q;
  logic [FADE_W-1:0]   fade_q;
  logic [SCROLL_W-1:0] scroll_q;
  logic [1:0]          scene_q;
  logic [7:0]          fcnt_q;
  logic                skip_pending_q;

  vga_frame_tick u_frame_tick (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .vsync_i     (vsync_i),
    .frame_tick_o(frame_tick)
  );

  assign advance = frame_tick & ~pause_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_FADE_IN;
      fade_q         <= FADE_MIN;
      scroll_q       <= '0;
      scene_q        <= '0;
      fcnt_q         <= '0;
      skip_pending_q <= 1'b0;
    end else if (advance) begin
      // Pending skip is consumed here; a skip arriving on this same tick waits for the next one.
      skip_pending_q <= skip_i;
      case (state_q)
        ST_FADE_IN: begin
          if (skip_pending_q) begin
            state_q <= ST_FADE_OUT;
            fcnt_q  <= '0;
          end else if (fcnt_q == FADE_LAST) begin
            fcnt_q <= '0;
            if (fade_q == FADE_MAX) begin
              state_q <= ST_HOLD;
            end else begin
              fade_q <= fade_q + 2'd1;
            end
          end else begin
            fcnt_q <= fcnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (skip_pending_q) begin
            state_q <= ST_FADE_OUT;
            fcnt_q  <= '0;
          end else begin
            scroll_q <= scroll_add(scroll_q, STEP);
            if (fcnt_q == HOLD_LAST) begin
              state_q <= ST_FADE_OUT;
              fcnt_q  <= '0;
            end else begin
              fcnt_q <= fcnt_q + 8'd1;
            end
          end
        end
        ST_FADE_OUT: begin
          if (fcnt_q == FADE_LAST) begin
            fcnt_q <= '0;
            if (fade_q == FADE_MIN) begin
              state_q <= ST_NEXT;
            end else begin
              fade_q <= fade_q - 2'd1;
            end
          end else begin
            fcnt_q <= fcnt_q + 8'd1;
          end
        end
        ST_NEXT: begin
          scene_q  <= (scene_q == SCENE_LAST) ? 2'd0 : scene_q + 2'd1;
          scroll_q <= '0;
          fade_q   <= FADE_MIN;
          fcnt_q   <= '0;
          state_q  <= ST_FADE_IN;
        end
        default: state_q <= ST_FADE_IN;
      endcase
    end else if (skip_i) begin
      skip_pending_q <= 1'b1;
    end
  end

  assign frame_tick_o = frame_tick;
  assign scroll_x_o   = scroll_q;
  assign fade_o       = fade_q;
  assign scene_id_o   = scene_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire
